avalon_st_gen: RTL and testbench
================================

AVALON_ST_GEN -- requirements
Module: avalon_st_gen

Interface
REQ-001 SHALL have one clock and reset: one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter MIN_LEN, default 64, minimum frame length in bytes, excluding CRC.
REQ-003 SHALL have parameter MAX_LEN, default 1518, maximum frame length in bytes.
REQ-004 SHALL have port clk  in  1  TX clock, shared with the MAC TX path.
REQ-005 SHALL have port reset  in  1  async reset, active-low.
REQ-006 SHALL have port avalon_mm_address  in  4  register word address.
REQ-007 SHALL have ports avalon_mm_write / avalon_mm_read  in  1  strobes.
REQ-008 SHALL have ports avalon_mm_writedata  in  32 and avalon_mm_readdata  out  32.
REQ-009 SHALL have port avalon_st_tx_data  out  64  frame data, first byte in [63:56].
REQ-010 SHALL have ports avalon_st_tx_valid, avalon_st_tx_sop, avalon_st_tx_eop, avalon_st_tx_error  out  1 each.
REQ-011 SHALL have port avalon_st_tx_empty  out  3  unused bytes in the EOP word.
REQ-012 SHALL have port avalon_st_tx_ready  in  1  MAC ready, readyLatency 0.
REQ-013 SHALL have ports gen_active and gen_done  out  1 each  run status.

Function
REQ-014 SHALL implement this register map: 0 NUM_PKTS[31:0], with 0 meaning run continuously; 1 PKT_LEN[13:0]; 2 CONFIG (bit0 random length, bit1 payload pattern 0=incrementing 1=0x55); 3 START (write 1); 4 STOP (write 1); 5 STATUS (bit0 active, bit1 done); 6 TX_PKT_CNT; 7 DST_MAC[31:0]; 8 DST_MAC[47:32] and SRC_MAC[47:32]; 9 SRC_MAC[31:0].
REQ-015 SHALL present readdata registered, one cycle after avalon_mm_read; unmapped addresses SHALL read 0.
REQ-016 SHALL clamp a PKT_LEN write into [MIN_LEN, MAX_LEN].
REQ-017 SHALL implement FSM IDLE -> HDR0 -> HDR1 -> PAYLOAD -> (HDR0 | DONE); DONE -> IDLE on START.
REQ-018 SHALL send HDR0 = DST_MAC and SRC_MAC[47:32], with sop=1.
REQ-019 SHALL send HDR1 = SRC_MAC[31:0], then 16-bit length field L-14, then 16-bit packet sequence number.
REQ-020 SHALL fill PAYLOAD bytes with the CONFIG bit1 pattern; the incrementing pattern restarts at 0x00 every frame.
REQ-021 SHALL use word count ceil(L/8); on the last word, eop=1 and empty=(8-L mod 8) mod 8.
REQ-022 SHALL advance a word only on valid & ready; while valid & !ready, data, sop, eop and empty SHALL hold stable.
REQ-023 SHALL assert valid on every cycle in HDR0, HDR1 and PAYLOAD, with no bubbles between frames.
REQ-024 SHALL increment TX_PKT_CNT on each accepted EOP word; the count SHALL wrap at 2^32.
REQ-025 SHALL enter DONE after the NUM_PKTS-th accepted EOP when NUM_PKTS != 0; gen_done=1 in DONE.
REQ-026 SHALL, on a STOP mid-frame, finish the current frame and then enter DONE; a STOP in IDLE is ignored.
REQ-027 SHALL ignore START while gen_active=1; START from IDLE or DONE SHALL clear TX_PKT_CNT, the sequence number and gen_done.
REQ-028 SHALL, when START and STOP are written in the same cycle as the last EOP, enter DONE.
REQ-029 SHALL hold avalon_st_tx_error constant at 0.

Reset
REQ-030 SHALL, on reset assertion, immediately drive all outputs to 0, the FSM to IDLE, all counters to 0, PKT_LEN to MIN_LEN and the other registers to 0.
REQ-031 SHALL abandon a frame when reset asserts mid-frame, with no EOP issued; after release, the first frame SHALL start with sop.

Configuration
REQ-032 SHALL provide random frame length under macro AVALON_ST_GEN_RANDLEN_EN: CONFIG bit0=1 selects per-frame L = MIN_LEN + lfsr[9:0], clamped to MAX_LEN, with the LFSR stepping once per frame.
REQ-033 SHALL, without AVALON_ST_GEN_RANDLEN_EN, omit the LFSR, make CONFIG bit0 read 0 and ignore writes to it, and always use PKT_LEN.

Structure
REQ-034 SHALL place register addresses, the FSM state enum, the MIN_LEN/MAX_LEN defaults and the LFSR polynomial/seed (x^16+x^14+x^13+x^11+1, seed 0xACE1) in package avalon_st_gen_pkg.
REQ-035 SHALL implement the LFSR as sub-module avalon_st_gen_lfsr (ports: clk, reset, step, value[15:0]).

Verification
REQ-036 SHALL verify: NUM_PKTS=2, PKT_LEN=64, ready=1 -> 2x8 words, eop on words 8 and 16, empty=0, seq 0 then 1, TX_PKT_CNT=2, gen_done=1.
REQ-037 SHALL verify: PKT_LEN=65 -> 9 words, last word empty=7, byte 64 of the frame = payload 0x32.
REQ-038 SHALL verify: ready toggled 1/0 on each cycle -> frame content identical to the ready=1 run, with data held while ready=0.
REQ-039 SHALL verify: NUM_PKTS=0, STOP on word 4 of frame 3 -> frame 3 completes, no sop follows, TX_PKT_CNT=3.
REQ-040 SHALL verify: reset asserted on word 5 -> valid=0 at once; after release and START the first word has sop=1 and seq=0.
REQ-041 SHALL verify: PKT_LEN write of 20, then of 2000 -> reads back 64, then 1518.

Source files
------------

// File: rtl/avalon_st_gen_pkg.sv
// Shared definitions for the Avalon-ST frame generator.
// Register map, FSM encoding, length defaults and LFSR constants.
package avalon_st_gen_pkg;

    localparam int DEF_MIN_LEN = 64;
    localparam int DEF_MAX_LEN = 1518;

    localparam logic [3:0] REG_NUM_PKTS = 4'd0;
    localparam logic [3:0] REG_PKT_LEN  = 4'd1;
    localparam logic [3:0] REG_CONFIG   = 4'd2;
    localparam logic [3:0] REG_START    = 4'd3;
    localparam logic [3:0] REG_STOP     = 4'd4;
    localparam logic [3:0] REG_STATUS   = 4'd5;
    localparam logic [3:0] REG_TX_CNT   = 4'd6;
    localparam logic [3:0] REG_DST_LO   = 4'd7;
    localparam logic [3:0] REG_MAC_HI   = 4'd8;
    localparam logic [3:0] REG_SRC_LO   = 4'd9;

    // x^16 + x^14 + x^13 + x^11 + 1, shift-left Fibonacci form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_PAYLOAD,
        S_DONE
    } state_e;

    function automatic logic [13:0] clamp_len(
        input logic [31:0] v,
        input int          lo,
        input int          hi
    );
        if (v < 32'(lo)) return 14'(lo);
        if (v > 32'(hi)) return 14'(hi);
        return 14'(v);
    endfunction

endpackage

// File: rtl/avalon_st_gen_lfsr.sv
// 16-bit Fibonacci LFSR that advances one step per asserted step.
module avalon_st_gen_lfsr
    import avalon_st_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (step) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/avalon_st_gen.sv
// Avalon-ST Ethernet test frame generator with Avalon-MM control.
// Random frame length is built in when AVALON_ST_GEN_RANDLEN_EN is defined.
module avalon_st_gen
    import avalon_st_gen_pkg::*;
#(
    parameter int MIN_LEN = DEF_MIN_LEN,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  avalon_mm_address,
    input  logic        avalon_mm_write,
    input  logic        avalon_mm_read,
    input  logic [31:0] avalon_mm_writedata,
    output logic [31:0] avalon_mm_readdata,
    output logic [63:0] avalon_st_tx_data,
    output logic        avalon_st_tx_valid,
    output logic        avalon_st_tx_sop,
    output logic        avalon_st_tx_eop,
    output logic        avalon_st_tx_error,
    output logic [2:0]  avalon_st_tx_empty,
    input  logic        avalon_st_tx_ready,
    output logic        gen_active,
    output logic        gen_done
);

    localparam logic [13:0] MIN_L = 14'(MIN_LEN);
`ifdef AVALON_ST_GEN_RANDLEN_EN
    localparam logic [13:0] MAX_L    = 14'(MAX_LEN);
    localparam logic [1:0]  CFG_MASK = 2'b11;
`else
    localparam logic [1:0]  CFG_MASK = 2'b10;
`endif

    logic [31:0] num_pkts_q;
    logic [13:0] pkt_len_q;
    logic [1:0]  cfg_q;
    logic [47:0] dst_mac_q;
    logic [47:0] src_mac_q;
    logic [31:0] rd_q, rd_d;

    state_e      state_q, state_d;
    logic [13:0] len_q, len_d;
    logic [10:0] rem_q, rem_d;
    logic [15:0] seq_q, seq_d;
    logic [7:0]  pat_q, pat_d;
    logic [31:0] cnt_q, cnt_d;
    logic        stop_q, stop_d;
    logic [63:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [2:0]  empty_q, empty_d;

    logic        wr_start, wr_stop;
    logic        adv, eof_acc, finish;
    logic        start_run, load_frame;
    logic [13:0] frame_len;
    logic [63:0] pay_word;

    assign wr_start = avalon_mm_write && avalon_mm_address == REG_START
                   && avalon_mm_writedata[0];
    assign wr_stop  = avalon_mm_write && avalon_mm_address == REG_STOP
                   && avalon_mm_writedata[0];

    assign gen_active = state_q == S_HDR0 || state_q == S_HDR1
                     || state_q == S_PAYLOAD;
    assign gen_done   = state_q == S_DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_pkts_q <= '0;
            pkt_len_q  <= MIN_L;
            cfg_q      <= '0;
            dst_mac_q  <= '0;
            src_mac_q  <= '0;
        end else if (avalon_mm_write) begin
            case (avalon_mm_address)
                REG_NUM_PKTS: num_pkts_q <= avalon_mm_writedata;
                REG_PKT_LEN:  pkt_len_q  <= clamp_len(avalon_mm_writedata,
                                                      MIN_LEN, MAX_LEN);
                REG_CONFIG:   cfg_q <= avalon_mm_writedata[1:0] & CFG_MASK;
                REG_DST_LO:   dst_mac_q[31:0] <= avalon_mm_writedata;
                REG_MAC_HI: begin
                    dst_mac_q[47:32] <= avalon_mm_writedata[31:16];
                    src_mac_q[47:32] <= avalon_mm_writedata[15:0];
                end
                REG_SRC_LO:   src_mac_q[31:0] <= avalon_mm_writedata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_d = '0;
        case (avalon_mm_address)
            REG_NUM_PKTS: rd_d = num_pkts_q;
            REG_PKT_LEN:  rd_d = {18'd0, pkt_len_q};
            REG_CONFIG:   rd_d = {30'd0, cfg_q};
            REG_STATUS:   rd_d = {30'd0, gen_done, gen_active};
            REG_TX_CNT:   rd_d = cnt_q;
            REG_DST_LO:   rd_d = dst_mac_q[31:0];
            REG_MAC_HI:   rd_d = {dst_mac_q[47:32], src_mac_q[47:32]};
            REG_SRC_LO:   rd_d = src_mac_q[31:0];
            default:      rd_d = '0;
        endcase
    end

`ifdef AVALON_ST_GEN_RANDLEN_EN
    logic [15:0] lfsr_val;
    logic [14:0] rnd_len;

    avalon_st_gen_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (load_frame && cfg_q[0]),
        .value (lfsr_val)
    );

    assign rnd_len   = {1'b0, MIN_L} + {5'd0, lfsr_val[9:0]};
    assign frame_len = !cfg_q[0]               ? pkt_len_q :
                       rnd_len > {1'b0, MAX_L} ? MAX_L     :
                                                 rnd_len[13:0];
`else
    assign frame_len = pkt_len_q;
`endif

    assign adv       = valid_q && avalon_st_tx_ready;
    assign eof_acc   = state_q == S_PAYLOAD && adv && rem_q == 11'd0;
    assign finish    = eof_acc && (stop_q || wr_stop
                    || (num_pkts_q != '0 && cnt_q + 32'd1 == num_pkts_q));
    assign start_run = wr_start && (state_q == S_IDLE || state_q == S_DONE);
    assign load_frame = start_run || (eof_acc && !finish);

    // Pattern byte equals its payload offset; offsets 0-1 hold the sequence
    always_comb begin
        pay_word = '0;
        for (int j = 0; j < 8; j++)
            pay_word[63-8*j -: 8] = cfg_q[1] ? 8'h55 : pat_q + 8'(j);
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        data_d  = data_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        empty_d = empty_q;
        if (wr_stop && gen_active) stop_d = 1'b1;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_run) begin
                    cnt_d  = '0;
                    seq_d  = '0;
                    stop_d = 1'b0;
                end
            end
            S_HDR0: begin
                if (adv) begin
                    state_d = S_HDR1;
                    data_d  = {src_mac_q[31:0],
                               {2'b00, len_q} - 16'd14, seq_q};
                    sop_d   = 1'b0;
                    rem_d   = rem_q - 11'd1;
                end
            end
            S_HDR1, S_PAYLOAD: begin
                if (adv && rem_q != 11'd0) begin
                    state_d = S_PAYLOAD;
                    data_d  = pay_word;
                    pat_d   = pat_q + 8'd8;
                    rem_d   = rem_q - 11'd1;
                    eop_d   = rem_q == 11'd1;
                    empty_d = rem_q == 11'd1 ? 3'd0 - len_q[2:0] : 3'd0;
                end else if (eof_acc) begin
                    cnt_d = cnt_q + 32'd1;
                    seq_d = seq_q + 16'd1;
                    if (finish) begin
                        state_d = S_DONE;
                        stop_d  = 1'b0;
                        data_d  = '0;
                        valid_d = 1'b0;
                        eop_d   = 1'b0;
                        empty_d = '0;
                    end
                end
            end
            default: ;
        endcase
        if (load_frame) begin
            state_d = S_HDR0;
            len_d   = frame_len;
            rem_d   = 11'((frame_len - 14'd1) >> 3);
            pat_d   = 8'd2;
            data_d  = {dst_mac_q, src_mac_q[47:32]};
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
            empty_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            rem_q   <= '0;
            seq_q   <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            empty_q <= empty_d;
            if (avalon_mm_read) rd_q <= rd_d;
        end
    end

    assign avalon_mm_readdata = rd_q;
    assign avalon_st_tx_data  = data_q;
    assign avalon_st_tx_valid = valid_q;
    assign avalon_st_tx_sop   = sop_q;
    assign avalon_st_tx_eop   = eop_q;
    assign avalon_st_tx_empty = empty_q;
    assign avalon_st_tx_error = 1'b0;

endmodule

// File: tb/tb_avalon_st_gen.sv
// Self-checking bench for avalon_st_gen: vector table plus
// scoreboard of expected stream beats.
module tb_avalon_st_gen;
    import avalon_st_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [63:0] tx_data;
    logic        tx_valid, tx_sop, tx_eop, tx_error;
    logic [2:0]  tx_empty;
    logic        tx_ready = 1'b0;
    logic        gen_active, gen_done;

    avalon_st_gen dut (
        .clk                 (clk),
        .reset               (reset),
        .avalon_mm_address   (address),
        .avalon_mm_write     (write),
        .avalon_mm_read      (read),
        .avalon_mm_writedata (writedata),
        .avalon_mm_readdata  (readdata),
        .avalon_st_tx_data   (tx_data),
        .avalon_st_tx_valid  (tx_valid),
        .avalon_st_tx_sop    (tx_sop),
        .avalon_st_tx_eop    (tx_eop),
        .avalon_st_tx_error  (tx_error),
        .avalon_st_tx_empty  (tx_empty),
        .avalon_st_tx_ready  (tx_ready),
        .gen_active          (gen_active),
        .gen_done            (gen_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [63:0] mask;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } beat_t;

    typedef struct {
        int         num;
        int         len;
        int         pat;
        int         rmode;
        int         words;
        int         cnt;
        logic [7:0] last_hi;
    } vec_t;

    localparam logic [47:0] DST = 48'h0011_2233_4455;
    localparam logic [47:0] SRC = 48'h6677_8899_AABB;

    beat_t       sbq[$];
    beat_t       e;
    vec_t        vecs[5];
    int          errors = 0;
    int          checks = 0;
    int          xfers = 0;
    int          rmode = 0;
    logic [63:0] last_eop = '0;
    logic        hold_pend = 1'b0;
    logic [63:0] h_data;
    logic        h_sop, h_eop;
    logic [2:0]  h_empty;

    initial forever begin
        @(negedge clk);
        case (rmode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (!reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                checks++;
                if (!tx_valid || tx_data !== h_data || tx_sop !== h_sop
                    || tx_eop !== h_eop || tx_empty !== h_empty) begin
                    errors++;
                    $display("FAIL hold: valid=%b data=%h sop=%b eop=%b empty=%0d, required 1 %h %b %b %0d",
                             tx_valid, tx_data, tx_sop, tx_eop, tx_empty,
                             h_data, h_sop, h_eop, h_empty);
                end
            end
            if (tx_valid && tx_ready) begin
                xfers++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL beat %0d: unexpected data=%h sop=%b, required no beat",
                             xfers, tx_data, tx_sop);
                end else begin
                    e = sbq.pop_front();
                    if (((tx_data ^ e.data) & e.mask) != 64'd0
                        || tx_sop !== e.sop || tx_eop !== e.eop
                        || tx_empty !== e.empty || tx_error !== 1'b0) begin
                        errors++;
                        $display("FAIL beat %0d: data=%h sop=%b eop=%b empty=%0d err=%b, required %h %b %b %0d 0",
                                 xfers, tx_data, tx_sop, tx_eop, tx_empty,
                                 tx_error, e.data, e.sop, e.eop, e.empty);
                    end
                end
                if (tx_eop) last_eop = tx_data;
            end
            hold_pend = tx_valid && !tx_ready;
            h_data  = tx_data;
            h_sop   = tx_sop;
            h_eop   = tx_eop;
            h_empty = tx_empty;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic mm_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        writedata = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic mm_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic setup(input int num, input int len, input int pat);
        mm_write(REG_DST_LO, DST[31:0]);
        mm_write(REG_MAC_HI, {DST[47:32], SRC[47:32]});
        mm_write(REG_SRC_LO, SRC[31:0]);
        mm_write(REG_NUM_PKTS, 32'(num));
        mm_write(REG_PKT_LEN, 32'(len));
        mm_write(REG_CONFIG, pat != 0 ? 32'd2 : 32'd0);
    endtask

    task automatic push_frame(input int len, input int seq, input int pat);
        beat_t b;
        int    nw;
        int    nb;
        nw = (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            b.sop   = w == 0;
            b.eop   = w == nw - 1;
            b.mask  = '1;
            b.empty = 3'd0;
            b.data  = '0;
            if (w == 0)
                b.data = {DST, SRC[47:32]};
            else if (w == 1)
                b.data = {SRC[31:0], 16'(len - 14), 16'(seq)};
            else
                for (int j = 0; j < 8; j++)
                    b.data[63-8*j -: 8] = pat != 0 ? 8'h55 : 8'(8*w + j - 14);
            if (b.eop) begin
                nb = len - 8*w;
                b.empty = 3'(8 - nb);
                b.mask = ~64'd0 << (8*(8 - nb));
            end
            sbq.push_back(b);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!gen_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(gen_done), 64'd1);
    endtask

    task automatic wait_xfers(input int base, input int target,
                              input string name);
        int n;
        n = 0;
        while (xfers - base < target && n < 1000) begin
            @(negedge clk);
            #3;
            n++;
        end
        check(name, 64'(xfers - base >= target), 64'd1);
    endtask

    logic [31:0] rd;
    int          base;

    initial begin
        vecs[0] = '{num: 2, len: 64, pat: 0, rmode: 0, words: 16, cnt: 2, last_hi: 8'h2A};
        vecs[1] = '{num: 1, len: 65, pat: 0, rmode: 0, words: 9,  cnt: 1, last_hi: 8'h32};
        vecs[2] = '{num: 2, len: 64, pat: 0, rmode: 1, words: 16, cnt: 2, last_hi: 8'h2A};
        vecs[3] = '{num: 1, len: 100, pat: 1, rmode: 0, words: 13, cnt: 1, last_hi: 8'h55};
        vecs[4] = '{num: 3, len: 71, pat: 0, rmode: 2, words: 27, cnt: 3, last_hi: 8'h32};

        #1 reset = 1'b0;
        #1;
        check("rst valid", 64'(tx_valid), 64'd0);
        check("rst outs", {tx_data[59:0], tx_sop, tx_eop, gen_active, gen_done}, 64'd0);
        check("rst empty", 64'({tx_empty, readdata}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        mm_read(REG_PKT_LEN, rd);
        check("rst pkt_len", 64'(rd), 64'd64);
        mm_read(REG_STATUS, rd);
        check("rst status", 64'(rd), 64'd0);
        mm_read(REG_TX_CNT, rd);
        check("rst txcnt", 64'(rd), 64'd0);
        mm_write(REG_STOP, 32'd1);
        mm_read(REG_STATUS, rd);
        check("idle stop", 64'(rd), 64'd0);

        mm_write(REG_PKT_LEN, 32'd20);
        mm_read(REG_PKT_LEN, rd);
        check("clamp low", 64'(rd), 64'd64);
        mm_write(REG_PKT_LEN, 32'd2000);
        mm_read(REG_PKT_LEN, rd);
        check("clamp high", 64'(rd), 64'd1518);
        mm_write(REG_PKT_LEN, 32'd100);
        mm_read(REG_PKT_LEN, rd);
        check("len 100", 64'(rd), 64'd100);
        mm_write(REG_CONFIG, 32'd3);
        mm_read(REG_CONFIG, rd);
`ifdef AVALON_ST_GEN_RANDLEN_EN
        check("config rb", 64'(rd), 64'd3);
`else
        check("config rb", 64'(rd), 64'd2);
`endif
        mm_read(4'd12, rd);
        check("unmapped", 64'(rd), 64'd0);

        for (int i = 0; i < 5; i++) begin
            rmode = vecs[i].rmode;
            setup(vecs[i].num, vecs[i].len, vecs[i].pat);
            for (int f = 0; f < vecs[i].num; f++)
                push_frame(vecs[i].len, f, vecs[i].pat);
            base = xfers;
            mm_write(REG_START, 32'd1);
            wait_done($sformatf("v%0d done", i));
            repeat (4) @(negedge clk);
            check($sformatf("v%0d words", i), 64'(xfers - base), 64'(vecs[i].words));
            check($sformatf("v%0d queue", i), 64'(sbq.size()), 64'd0);
            mm_read(REG_TX_CNT, rd);
            check($sformatf("v%0d txcnt", i), 64'(rd), 64'(vecs[i].cnt));
            mm_read(REG_STATUS, rd);
            check($sformatf("v%0d status", i), 64'(rd), 64'd2);
            check($sformatf("v%0d last byte", i), 64'(last_eop[63:56]), 64'(vecs[i].last_hi));
            sbq.delete();
        end

        rmode = 0;
        setup(0, 64, 0);
        for (int f = 0; f < 3; f++) push_frame(64, f, 0);
        base = xfers;
        mm_write(REG_START, 32'd1);
        wait_xfers(base, 19, "stop wait");
        mm_write(REG_STOP, 32'd1);
        wait_done("stop done");
        repeat (10) @(negedge clk);
        check("stop words", 64'(xfers - base), 64'd24);
        check("stop idle", 64'(tx_valid), 64'd0);
        mm_read(REG_TX_CNT, rd);
        check("stop txcnt", 64'(rd), 64'd3);
        sbq.delete();

        setup(0, 64, 0);
        push_frame(64, 0, 0);
        base = xfers;
        mm_write(REG_START, 32'd1);
        wait_xfers(base, 8, "eop stop wait");
        address = REG_STOP;
        writedata = 32'd1;
        write = 1'b1;
        @(posedge clk);
        #1 write = 1'b0;
        wait_done("eop stop done");
        repeat (6) @(negedge clk);
        check("eop stop words", 64'(xfers - base), 64'd8);
        mm_read(REG_TX_CNT, rd);
        check("eop stop txcnt", 64'(rd), 64'd1);
        sbq.delete();

        setup(0, 64, 0);
        push_frame(64, 0, 0);
        base = xfers;
        mm_write(REG_START, 32'd1);
        wait_xfers(base, 4, "rst wait");
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst valid", 64'(tx_valid), 64'd0);
        check("midrst outs", {tx_data[60:0], tx_sop, tx_eop, gen_active}, 64'd0);
        sbq.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        mm_read(REG_DST_LO, rd);
        check("midrst dst", 64'(rd), 64'd0);
        setup(1, 64, 0);
        push_frame(64, 0, 0);
        base = xfers;
        mm_write(REG_START, 32'd1);
        wait_done("post rst done");
        repeat (4) @(negedge clk);
        check("post rst words", 64'(xfers - base), 64'd8);
        check("post rst queue", 64'(sbq.size()), 64'd0);
        mm_read(REG_TX_CNT, rd);
        check("post rst txcnt", 64'(rd), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
